// File: rtl/types_pkg.sv
// Shared types for the experiment front end: conditioned input bundle,
// phase-lock states and the run-time tuning parameters.
package types_pkg;

    localparam int DEBOUNCE_W_DEF = 16;
    localparam int PERIOD_W_DEF   = 24;

    typedef struct packed {
        logic start;
        logic fg_opto;
        logic wire_sensor;
        logic detector_ready;
        logic phase;
    } input_signals_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } phase_lock_state_t;

    typedef struct packed {
        logic [DEBOUNCE_W_DEF-1:0] debounce_len;
        logic [PERIOD_W_DEF-1:0]   phase_tol;
    } parameters_t;

endpackage

// File: rtl/sync_debounce.sv
// One slow field input: reset-to-0 synchronizer chain followed by a
// counting debounce filter with a registered output.
module sync_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  raw,
    input  logic [DEBOUNCE_W-1:0] debounce_len,
    output logic                  clean
);

    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = DEBOUNCE_W'(1'b1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [DEBOUNCE_W-1:0]  cnt_r;
    logic                   clean_r;
    logic                   synced_s;

    assign synced_s = sync_r[SYNC_STAGES-1];
    assign clean    = clean_r;

    // Synchronizer chain into the clock domain
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce: output flips only after the input has differed for debounce_len+1 samples
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r   <= '0;
            clean_r <= 1'b0;
        end else if (synced_s == clean_r) begin
            cnt_r   <= '0;
        end else if (cnt_r >= debounce_len) begin
            clean_r <= synced_s;
            cnt_r   <= '0;
        end else begin
            cnt_r   <= cnt_r + CNT_ONE;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Field-input front end: synchronizes and debounces the slow channels,
// measures the phase-reference period and tracks phase lock.
module input_conditioner
    import types_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = DEBOUNCE_W_DEF,
    parameter int PERIOD_W    = PERIOD_W_DEF,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  raw_start,
    input  logic                  raw_fg_opto,
    input  logic                  raw_wire_sensor,
    input  logic                  raw_detector_ready,
    input  logic                  raw_phase,
    input  logic [DEBOUNCE_W-1:0] debounce_len,
    input  logic [PERIOD_W-1:0]   phase_tol,
    output input_signals_t        cond,
    output logic [PERIOD_W-1:0]   phase_period,
    output logic                  phase_locked,
    output logic                  phase_lost
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]       MATCH_ONE  = MW'(1'b1);
    localparam logic [MW-1:0]       LOCK_LAST  = MW'(LOCK_COUNT - 1);
    localparam logic [PERIOD_W-1:0] PCNT_ONE   = PERIOD_W'(1'b1);
    localparam logic [PERIOD_W-1:0] PCNT_MAX   = {PERIOD_W{1'b1}};
    localparam logic [PERIOD_W:0]   WIDE_ONE   = (PERIOD_W + 1)'(1'b1);

    function automatic logic [PERIOD_W:0] abs_diff(input logic [PERIOD_W:0] a,
                                                   input logic [PERIOD_W:0] b);
        if (a >= b) begin
            abs_diff = a - b;
        end else begin
            abs_diff = b - a;
        end
    endfunction

    logic start_s, fg_opto_s, wire_sensor_s, detector_ready_s;

    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W)) u_start (
        .clock(clock), .reset(reset), .raw(raw_start),
        .debounce_len(debounce_len), .clean(start_s));
    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W)) u_fg_opto (
        .clock(clock), .reset(reset), .raw(raw_fg_opto),
        .debounce_len(debounce_len), .clean(fg_opto_s));
    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W)) u_wire_sensor (
        .clock(clock), .reset(reset), .raw(raw_wire_sensor),
        .debounce_len(debounce_len), .clean(wire_sensor_s));
    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_W(DEBOUNCE_W)) u_detector_ready (
        .clock(clock), .reset(reset), .raw(raw_detector_ready),
        .debounce_len(debounce_len), .clean(detector_ready_s));

    logic [SYNC_STAGES-1:0] psync_r;
    logic                   phase_r;
    logic                   rise_s;
    logic [PERIOD_W-1:0]    pcnt_r;
    logic [PERIOD_W-1:0]    ref_period_r;
    logic [PERIOD_W-1:0]    phase_period_r;
    logic [MW-1:0]          match_r;
    logic                   first_r;
    logic                   locked_r;
    logic                   lost_r;
    phase_lock_state_t      state_r;

    logic [PERIOD_W:0]      period_s;
    logic [PERIOD_W-1:0]    period_clip_s;
    logic [PERIOD_W:0]      dev_s;
    logic [PERIOD_W:0]      limit_s;
    logic                   in_tol_s;
    logic                   missed_s;
    logic                   pcnt_sat_s;

    assign cond = '{start:          start_s,
                    fg_opto:        fg_opto_s,
                    wire_sensor:    wire_sensor_s,
                    detector_ready: detector_ready_s,
                    phase:          phase_r};
    assign phase_period = phase_period_r;
    assign phase_locked = locked_r;
    assign phase_lost   = lost_r;
    assign rise_s       = psync_r[SYNC_STAGES-1] & ~phase_r;

    // Phase reference synchronizer plus the delay flop used for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            psync_r <= '0;
            phase_r <= 1'b0;
        end else begin
            psync_r <= {psync_r[SYNC_STAGES-2:0], raw_phase};
            phase_r <= psync_r[SYNC_STAGES-1];
        end
    end

    // Saturating cycles-since-last-edge counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pcnt_r <= '0;
        end else if (rise_s) begin
            pcnt_r <= '0;
        end else if (pcnt_r != PCNT_MAX) begin
            pcnt_r <= pcnt_r + PCNT_ONE;
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

    // Period, deviation and missed-edge evaluation, all one bit wider to avoid wrap
    always_comb begin
        period_s      = {1'b0, pcnt_r} + WIDE_ONE;
        period_clip_s = pcnt_r;
        if (period_s[PERIOD_W]) begin
            period_clip_s = PCNT_MAX;
        end else begin
            period_clip_s = period_s[PERIOD_W-1:0];
        end
        dev_s      = abs_diff(period_s, {1'b0, ref_period_r});
        limit_s    = {1'b0, ref_period_r} + {1'b0, phase_tol};
        in_tol_s   = (dev_s <= {1'b0, phase_tol});
        missed_s   = ({1'b0, pcnt_r} > limit_s);
        pcnt_sat_s = (pcnt_r == PCNT_MAX);
    end

    // Lock FSM with registered period, lock and loss outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            ref_period_r   <= '0;
            phase_period_r <= '0;
            match_r        <= '0;
            first_r        <= 1'b0;
            locked_r       <= 1'b0;
            lost_r         <= 1'b0;
        end else begin
            lost_r <= 1'b0;
            if (rise_s && (state_r != IDLE)) begin
                phase_period_r <= period_clip_s;
            end
            case (state_r)
                IDLE: begin
                    locked_r <= 1'b0;
                    if (rise_s) begin
                        match_r <= '0;
                        first_r <= 1'b1;
                        state_r <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise_s) begin
                        if (first_r || !in_tol_s) begin
                            ref_period_r <= period_clip_s;
                            match_r      <= '0;
                            first_r      <= 1'b0;
                        end else if (match_r == LOCK_LAST) begin
                            match_r  <= match_r + MATCH_ONE;
                            locked_r <= 1'b1;
                            state_r  <= LOCKED;
                        end else begin
                            match_r <= match_r + MATCH_ONE;
                        end
                    end else if (pcnt_sat_s) begin
                        state_r <= IDLE;
                    end
                end
                LOCKED: begin
                    if (rise_s) begin
                        if (!in_tol_s) begin
                            lost_r       <= 1'b1;
                            locked_r     <= 1'b0;
                            ref_period_r <= period_clip_s;
                            match_r      <= '0;
                            first_r      <= 1'b0;
                            state_r      <= MEASURE;
                        end
                    end else if (missed_s) begin
                        lost_r   <= 1'b1;
                        locked_r <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    locked_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner: debounce, passthrough,
// lock acquisition, period jump, missed edge and asynchronous reset.
module tb_input_conditioner;
    import types_pkg::*;

    logic           clock;
    logic           reset;
    logic           raw_start, raw_fg_opto, raw_wire_sensor, raw_detector_ready, raw_phase;
    logic [15:0]    debounce_len;
    logic [23:0]    phase_tol;
    input_signals_t cond;
    logic [23:0]    phase_period;
    logic           phase_locked;
    logic           phase_lost;

    int checks = 0;
    int errors = 0;

    input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_W(16), .PERIOD_W(24), .LOCK_COUNT(4)) dut (
        .clock(clock), .reset(reset),
        .raw_start(raw_start), .raw_fg_opto(raw_fg_opto), .raw_wire_sensor(raw_wire_sensor),
        .raw_detector_ready(raw_detector_ready), .raw_phase(raw_phase),
        .debounce_len(debounce_len), .phase_tol(phase_tol),
        .cond(cond), .phase_period(phase_period),
        .phase_locked(phase_locked), .phase_lost(phase_lost));

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a phase rise; the synced edge has been acted on 3 ticks later
    task automatic phase_rise();
        raw_phase = 1'b1;
        repeat (3) tick();
    endtask

    task automatic phase_rest(input int per, input int used);
        repeat (per / 2 - used) tick();
        raw_phase = 1'b0;
        repeat (per - per / 2) tick();
    endtask

    initial begin
        clock = 1'b0; reset = 1'b0;
        raw_start = 1'b0; raw_fg_opto = 1'b0; raw_wire_sensor = 1'b0;
        raw_detector_ready = 1'b0; raw_phase = 1'b0;
        debounce_len = 16'd10; phase_tol = 24'd2;
        #12;
        check("rst_cond",   32'(cond), 32'd0);
        check("rst_period", 32'(phase_period), 32'd0);
        check("rst_locked", 32'(phase_locked), 32'd0);
        check("rst_lost",   32'(phase_lost), 32'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();

        // Debounce: an 8-cycle glitch is filtered, a 20-cycle pulse passes after 13
        raw_start = 1'b1;
        repeat (8) tick();
        raw_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("glitch_filtered", 32'(cond.start), 32'd0);
        end
        raw_start = 1'b1;
        repeat (12) tick();
        check("deb_rise_early", 32'(cond.start), 32'd0);
        tick();
        check("deb_rise", 32'(cond.start), 32'd1);
        repeat (7) tick();
        raw_start = 1'b0;
        repeat (12) tick();
        check("deb_fall_early", 32'(cond.start), 32'd1);
        tick();
        check("deb_fall", 32'(cond.start), 32'd0);

        // Passthrough with zero debounce length
        debounce_len = 16'd0;
        raw_wire_sensor = 1'b1;
        repeat (2) tick();
        check("pass_rise_early", 32'(cond.wire_sensor), 32'd0);
        tick();
        check("pass_rise", 32'(cond.wire_sensor), 32'd1);
        raw_wire_sensor = 1'b0;
        repeat (2) tick();
        check("pass_fall_early", 32'(cond.wire_sensor), 32'd1);
        tick();
        check("pass_fall", 32'(cond.wire_sensor), 32'd0);
        debounce_len = 16'd10;

        // Lock acquisition at 240 cycles
        raw_phase = 1'b1;
        repeat (2) tick();
        check("phase_lat_early", 32'(cond.phase), 32'd0);
        tick();
        check("phase_lat", 32'(cond.phase), 32'd1);
        check("period_from_idle", 32'(phase_period), 32'd0);
        check("lock_e1", 32'(phase_locked), 32'd0);
        phase_rest(240, 3);
        for (int i = 2; i <= 5; i++) begin
            phase_rise();
            check("lock_early", 32'(phase_locked), 32'd0);
            if (i == 2) check("period_240", 32'(phase_period), 32'd240);
            phase_rest(240, 3);
        end
        phase_rise();
        check("lock_e6", 32'(phase_locked), 32'd1);
        check("lock_no_lost", 32'(phase_lost), 32'd0);
        check("lock_period", 32'(phase_period), 32'd240);
        phase_rest(240, 3);
        phase_rise();
        check("lock_hold", 32'(phase_locked), 32'd1);

        // Period jump to 230 cycles: lost pulse, then re-lock after 4 matches
        phase_rest(230, 3);
        phase_rise();
        check("jump_lost", 32'(phase_lost), 32'd1);
        check("jump_unlock", 32'(phase_locked), 32'd0);
        tick();
        check("jump_lost_1cyc", 32'(phase_lost), 32'd0);
        check("jump_period", 32'(phase_period), 32'd230);
        phase_rest(230, 4);
        for (int i = 0; i < 3; i++) begin
            phase_rise();
            check("relock_early", 32'(phase_locked), 32'd0);
            phase_rest(230, 3);
        end
        phase_rise();
        check("relock", 32'(phase_locked), 32'd1);
        check("relock_no_lost", 32'(phase_lost), 32'd0);
        phase_rest(230, 3);

        // Missed edge: ref 230, tol 2, loss registered once pcnt reaches 233
        phase_rise();
        check("miss_locked_edge", 32'(phase_locked), 32'd1);
        repeat (112) tick();
        raw_phase = 1'b0;
        repeat (121) tick();
        check("miss_not_yet", 32'(phase_lost), 32'd0);
        check("miss_still_lock", 32'(phase_locked), 32'd1);
        tick();
        check("miss_lost", 32'(phase_lost), 32'd1);
        check("miss_unlock", 32'(phase_locked), 32'd0);
        tick();
        check("miss_lost_1cyc", 32'(phase_lost), 32'd0);

        // Re-acquire from IDLE with start held high
        raw_start = 1'b1;
        phase_rise();
        check("idle_period_kept", 32'(phase_period), 32'd230);
        phase_rest(240, 3);
        for (int i = 2; i <= 5; i++) begin
            phase_rise();
            check("acq2_early", 32'(phase_locked), 32'd0);
            phase_rest(240, 3);
        end
        phase_rise();
        check("acq2_lock", 32'(phase_locked), 32'd1);
        check("acq2_start", 32'(cond.start), 32'd1);

        // Asynchronous reset while locked and mid-debounce
        raw_detector_ready = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        #1;
        check("mid_rst_cond",   32'(cond), 32'd0);
        check("mid_rst_period", 32'(phase_period), 32'd0);
        check("mid_rst_locked", 32'(phase_locked), 32'd0);
        check("mid_rst_lost",   32'(phase_lost), 32'd0);
        tick();
        raw_phase = 1'b0;
        tick();
        reset = 1'b1;
        repeat (12) tick();
        check("post_rst_det_early", 32'(cond.detector_ready), 32'd0);
        check("post_rst_start_early", 32'(cond.start), 32'd0);
        tick();
        check("post_rst_det", 32'(cond.detector_ready), 32'd1);
        check("post_rst_start", 32'(cond.start), 32'd1);

        phase_rise();
        check("acq3_idle_period", 32'(phase_period), 32'd0);
        phase_rest(240, 3);
        for (int i = 2; i <= 5; i++) begin
            phase_rise();
            check("acq3_early", 32'(phase_locked), 32'd0);
            if (i == 2) check("acq3_period", 32'(phase_period), 32'd240);
            phase_rest(240, 3);
        end
        phase_rise();
        check("acq3_lock", 32'(phase_locked), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
